// File: rtl/cache_fill_fsm.sv
// Line-fill controller: on a miss, issues LINE_WORDS pipelined word reads and steers the returns
// into the data array, writing the tag on the last return. CRITICAL_WORD_FIRST_EN starts at the missed word.
module cache_fill_fsm #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned WORD_BYTES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          miss_detected,
  input  logic [ADDR_W-1:0]             miss_address,
  input  logic                          memory_data_valid,
  output logic                          fsm_busy,
  output logic                          mem_read_req,
  output logic [ADDR_W-1:0]             memory_address,
  output logic                          write_data_array,
  output logic [$clog2(LINE_WORDS)-1:0] word_index,
  output logic                          write_tag_array
);

  localparam int unsigned OFS   = $clog2(LINE_WORDS * WORD_BYTES);
  localparam int unsigned WB    = $clog2(WORD_BYTES);
  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;

  localparam logic [ADDR_W-1:0] OfsMask  = ADDR_W'((2 ** OFS) - 1);
  localparam logic [CNT_W-1:0]  LineCnt  = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0]  LastRet  = CNT_W'(LINE_WORDS - 1);

  typedef enum logic {StIdle, StFill} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   ret_cnt_q, ret_cnt_d;
  logic [IDX_W-1:0]   start_idx_q, start_idx_d;
  logic [IDX_W-1:0]   req_idx, ret_idx;
  logic [IDX_W-1:0]   miss_idx;

`ifdef CRITICAL_WORD_FIRST_EN
  assign miss_idx = miss_address[OFS-1:WB];
`else
  logic unused_low_bits;
  assign unused_low_bits = ^miss_address[OFS-1:0];
  assign miss_idx        = '0;
`endif

  // Slot arithmetic is IDX_W bits wide, so it wraps within the line.
  assign req_idx = start_idx_q + issue_cnt_q[IDX_W-1:0];
  assign ret_idx = start_idx_q + ret_cnt_q[IDX_W-1:0];

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    issue_cnt_d      = issue_cnt_q;
    ret_cnt_d        = ret_cnt_q;
    start_idx_d      = start_idx_q;
    fsm_busy         = 1'b0;
    mem_read_req     = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_index       = '0;
    write_tag_array  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (miss_detected) begin
          base_d      = miss_address & ~OfsMask;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          start_idx_d = miss_idx;
          state_d     = StFill;
        end
      end
      StFill: begin
        fsm_busy = 1'b1;
        if (issue_cnt_q < LineCnt) begin
          mem_read_req   = 1'b1;
          memory_address = base_q + (ADDR_W'(req_idx) << WB);
          issue_cnt_d    = issue_cnt_q + 1'b1;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_index       = ret_idx;
          ret_cnt_d        = ret_cnt_q + 1'b1;
          if (ret_cnt_q == LastRet) begin
            write_tag_array = 1'b1;
            state_d         = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      start_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      start_idx_q <= start_idx_d;
    end
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Parametrised line-fill controller for the next-generation memory system. Replaces single-cycle instruction/data memory access with a cache backed by multi-cycle, pipelined main memory.
- On a cache miss it issues LINE_WORDS consecutive word reads and steers each returned word into the cache data array. It writes the tag on the final word.
- One instance sits beside each cache (I and D). An arbiter upstream serialises memory access.

Parameters:
- ADDR_W, 16, byte-address width.
- LINE_WORDS, 8, words per cache line; power of 2, at least 2.
- WORD_BYTES, 2, bytes per word; power of 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- miss_detected  in  1  cache miss; level, held by requester until the fill completes.
- miss_address  in  ADDR_W  byte address of the missing access; valid while miss_detected is high.
- memory_data_valid  in  1  main memory returns one word this cycle. Returns are in request order, any fixed latency.
- fsm_busy  out  1  fill in progress; cache stalls the pipeline.
- mem_read_req  out  1  read request to main memory this cycle.
- memory_address  out  ADDR_W  byte address of the current request.
- write_data_array  out  1  write the returned word into the data array this cycle.
- word_index  out  $clog2(LINE_WORDS)  word slot in the line for the current data write.
- write_tag_array  out  1  write tag/valid for the line; one-cycle pulse.

Behaviour:
Localparams:
- OFS = $clog2(LINE_WORDS*WORD_BYTES).
- WB = $clog2(WORD_BYTES).

States: IDLE and FILL, plus registers:
- base: ADDR_W bits, line base address.
- issue_cnt: $clog2(LINE_WORDS)+1 bits.
- ret_cnt: $clog2(LINE_WORDS)+1 bits.
- start_idx: $clog2(LINE_WORDS) bits.

IDLE:
- fsm_busy=0.
- miss_detected=1 latches base = miss_address with the low OFS bits forced to 0, clears both counters, and moves to FILL on that edge.
- memory_data_valid is ignored in IDLE (no writes).

FILL:
- fsm_busy=1.
- Requests: mem_read_req=1 while issue_cnt<LINE_WORDS, one request per cycle with no gaps. The first request is in the first FILL cycle, so latency from miss to first request is 1 cycle.
- Request address: memory_address = base + (((start_idx+issue_cnt) mod LINE_WORDS) << WB). Arithmetic is ADDR_W bits and never carries out of the line.
- Returns: memory_data_valid=1 gives write_data_array=1 and word_index = (start_idx+ret_cnt) mod LINE_WORDS, then ret_cnt increments.
- Completion: the return with ret_cnt==LINE_WORDS-1 also asserts write_tag_array=1 in the same cycle. Next state is IDLE.
- A valid can arrive in the same cycle as a request; both are processed.

Boundary and corner rules:
- miss_detected and miss_address are ignored in FILL.
- A miss still asserted in the first IDLE cycle after completion starts a new fill, so back-to-back fills are separated by exactly one IDLE cycle.
- Returns beyond LINE_WORDS cannot occur. If one arrives in IDLE it is ignored.
- Reset mid-fill: immediate return to IDLE with counters cleared. Outstanding memory returns arriving after reset release produce no writes.

Outputs:
- All outputs are decoded from the state and registers.
- memory_address is 0 when mem_read_req=0.
- word_index is 0 when write_data_array=0.

Reset values:
- State IDLE; base, counters and start_idx 0.
- fsm_busy, mem_read_req, write_data_array and write_tag_array are 0.
- memory_address and word_index are 0.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined: on miss, start_idx = miss_address[OFS-1:WB]. Requests and word_index start at the missing word and wrap modulo LINE_WORDS.
- Undefined: start_idx is held at 0 and the line fills in order 0..LINE_WORDS-1.
- The tag write is on the LINE_WORDS-th return in both cases.

Test Plan (defaults, memory latency 4 cycles, one return per request):
- Plain fill, macro off. miss_address=0x1234, held -> base 0x1230. Requests 0x1230,0x1232,…,0x123E on 8 consecutive cycles starting 1 cycle after the miss. write_data_array with word_index 0..7 on 8 consecutive cycles. write_tag_array on the 8th. fsm_busy high for 12 cycles, then IDLE.
- Critical word first, macro on. miss_address=0x123A -> requests 0x123A,0x123C,0x123E,0x1230,0x1232,0x1234,0x1236,0x1238. word_index sequence 5,6,7,0,1,2,3,4. Tag on the last.
- Reset mid-fill. rst_n low after 3 returns -> all outputs 0 asynchronously. Remaining 5 memory_data_valid pulses after release produce no write_data_array or write_tag_array.
- Miss during fill. Toggle miss_address to 0x4000 in FILL -> ignored. Miss held past completion -> one IDLE cycle, then a new fill at base 0x4000.
- Spurious valid. memory_data_valid pulsed in IDLE with no miss -> no writes; fsm_busy stays 0.
- Top of address space. miss_address=0xFFFF -> base 0xFFF0, requests up to 0xFFFE, no wrap to 0x0000. Tag written after 8 returns.
